// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns datapath load/store requests into a
// req/ack memory transaction, stalling the pipeline until it completes.
module dmem_ctrl #(
  parameter int TIMEOUT = 16,
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned,
  output logic        buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             start;
  logic             bad;
  logic             abort;

  assign acc = memread | memwrite;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // DONE never looks at the request inputs, so a finished access is not re-issued.
  always_comb begin
    next    = state;
    stall   = 1'b0;
    mem_req = 1'b0;
    start   = 1'b0;
    bad     = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (addr[1:0] == 2'b00) begin
            stall = 1'b1;
            start = 1'b1;
            next  = BUSY;
          end else begin
            bad = 1'b1;
          end
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          next = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort = 1'b1;
          next  = DONE;
        end
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Request fields are captured once on entry to BUSY and held until the next access.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      misaligned <= 1'b0;
      buserr     <= 1'b0;
      cnt        <= '0;
    end else begin
      misaligned <= bad;
      buserr     <= abort;
      if (start) begin
        mem_we    <= memwrite;
        mem_addr  <= addr[31:2];
        mem_wdata <= writedata;
        cnt       <= '0;
      end
      if (state == BUSY) begin
        if (mem_ack) begin
          cnt <= '0;
          if (!mem_we) readdata <= mem_rdata;
        end else if (abort) begin
          cnt      <= '0;
          readdata <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: loads, stores, misaligned,
// timeout, back-to-back and mid-access reset scenarios.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;
  logic        buserr;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int testCount = 0;
  int failCount = 0;

  dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .memread(memread),
    .memwrite(memwrite),
    .addr(addr),
    .writedata(writedata),
    .readdata(readdata),
    .stall(stall),
    .misaligned(misaligned),
    .buserr(buserr),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs just after the falling edge, settle, then return.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic ack,
                               input logic [31:0] rdat);
    @(negedge clk);
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    writedata = wd;
    mem_ack   = ack;
    mem_rdata = rdat;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_flags", {30'h0, misaligned, buserr}, 32'h0);

    // Load with immediate ack
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checkOutput("ld_idle_stall", 32'(stall), 32'h1);
    checkOutput("ld_idle_req", 32'(mem_req), 32'h0);
    applyStimulus(1, 0, 32'h10, 32'h0, 1, 32'hCAFE_F00D);
    checkOutput("ld_busy_req", 32'(mem_req), 32'h1);
    checkOutput("ld_busy_stall", 32'(stall), 32'h1);
    checkOutput("ld_mem_addr", 32'(mem_addr), 32'h4);
    checkOutput("ld_mem_we", 32'(mem_we), 32'h0);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checkOutput("ld_done_stall", 32'(stall), 32'h0);
    checkOutput("ld_done_req", 32'(mem_req), 32'h0);
    checkOutput("ld_readdata", readdata, 32'hCAFE_F00D);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("ld_after_req", 32'(mem_req), 32'h0);
    checkOutput("ld_after_stall", 32'(stall), 32'h0);

    // Store acked on the 3rd BUSY cycle; rdata garbage must not reach readdata
    applyStimulus(0, 1, 32'h20, 32'h1234_5678, 0, 32'h0);
    checkOutput("st_idle_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h20, 32'h1234_5678, (i == 2), 32'hBAD0_BAD0);
      checkOutput("st_busy_req", 32'(mem_req), 32'h1);
      checkOutput("st_busy_stall", 32'(stall), 32'h1);
      checkOutput("st_mem_we", 32'(mem_we), 32'h1);
      checkOutput("st_mem_addr", 32'(mem_addr), 32'h8);
      checkOutput("st_mem_wdata", mem_wdata, 32'h1234_5678);
    end
    applyStimulus(0, 1, 32'h20, 32'h1234_5678, 0, 32'h0);
    checkOutput("st_done_req", 32'(mem_req), 32'h0);
    checkOutput("st_done_stall", 32'(stall), 32'h0);
    checkOutput("st_readdata", readdata, 32'hCAFE_F00D);

    // Misaligned load
    applyStimulus(1, 0, 32'h13, 32'h0, 0, 32'h0);
    checkOutput("mis_stall", 32'(stall), 32'h0);
    checkOutput("mis_req", 32'(mem_req), 32'h0);
    checkOutput("mis_flag_pre", 32'(misaligned), 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("mis_flag", 32'(misaligned), 32'h1);
    checkOutput("mis_req2", 32'(mem_req), 32'h0);
    checkOutput("mis_readdata", readdata, 32'hCAFE_F00D);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("mis_flag_end", 32'(misaligned), 32'h0);

    // Timeout: exactly 16 BUSY cycles, then buserr pulse
    applyStimulus(1, 0, 32'h40, 32'h0, 0, 32'h0);
    checkOutput("to_idle_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 32'h40, 32'h0, 0, 32'h0);
      checkOutput("to_busy_req", 32'(mem_req), 32'h1);
      checkOutput("to_busy_buserr", 32'(buserr), 32'h0);
    end
    applyStimulus(1, 0, 32'h40, 32'h0, 0, 32'h0);
    checkOutput("to_done_req", 32'(mem_req), 32'h0);
    checkOutput("to_done_buserr", 32'(buserr), 32'h1);
    checkOutput("to_done_misaligned", 32'(misaligned), 32'h0);
    checkOutput("to_readdata", readdata, 32'h0);
    checkOutput("to_done_stall", 32'(stall), 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h5555_AAAA);
    checkOutput("to_late_buserr", 32'(buserr), 32'h0);
    checkOutput("to_late_req", 32'(mem_req), 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("to_late_req2", 32'(mem_req), 32'h0);
    checkOutput("to_late_readdata", readdata, 32'h0);

    // Back-to-back load then store
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h8, 32'h0, 1, 32'hA5A5_0001);
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("b2b_done_req", 32'(mem_req), 32'h0);
    checkOutput("b2b_ld_data", readdata, 32'hA5A5_0001);
    applyStimulus(0, 1, 32'hC, 32'hDEAD_BEEF, 0, 32'h0);
    checkOutput("b2b_idle_req", 32'(mem_req), 32'h0);
    checkOutput("b2b_idle_stall", 32'(stall), 32'h1);
    applyStimulus(0, 1, 32'hC, 32'hDEAD_BEEF, 1, 32'h0);
    checkOutput("b2b_st_req", 32'(mem_req), 32'h1);
    checkOutput("b2b_st_addr", 32'(mem_addr), 32'h3);
    checkOutput("b2b_st_we", 32'(mem_we), 32'h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("b2b_st_readdata", readdata, 32'hA5A5_0001);

    // Reset during the 2nd BUSY cycle
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h50, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h50, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h50, 32'h0, 0, 32'h0);
    reset = 1'b1;
    checkOutput("rm_busy_req", 32'(mem_req), 32'h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    checkOutput("rm_req", 32'(mem_req), 32'h0);
    checkOutput("rm_stall", 32'(stall), 32'h0);
    checkOutput("rm_readdata", readdata, 32'h0);
    checkOutput("rm_mem_addr", 32'(mem_addr), 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("rm_idle_req", 32'(mem_req), 32'h0);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checkOutput("rm_ld_stall", 32'(stall), 32'h1);
    applyStimulus(1, 0, 32'h10, 32'h0, 1, 32'h600D_F00D);
    checkOutput("rm_ld_req", 32'(mem_req), 32'h1);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checkOutput("rm_ld_readdata", readdata, 32'h600D_F00D);
    checkOutput("rm_ld_done_stall", 32'(stall), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
